// File: rtl/bsg_counter_snapshot_pkg.sv
// Shared types and defaults for the interval counter-snapshot block.
// Optional timestamp field is controlled by BSG_COUNTER_SNAPSHOT_TIMESTAMP_EN.
package bsg_counter_snapshot_pkg;

    localparam int width_default_lp          = 64;
    localparam int interval_width_default_lp = 32;
    localparam int els_default_lp            = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } state_e;

    // Entry layout at the default width; the top builds the same layout at width_p.
    typedef struct packed {
`ifdef BSG_COUNTER_SNAPSHOT_TIMESTAMP_EN
        logic [width_default_lp-1:0] ts;
`endif
        logic [width_default_lp-1:0] count;
    } snapshot_entry_s;

    function automatic int ptr_width(input int els);
        return (els > 1) ? $clog2(els) : 1;
    endfunction

endpackage

// File: rtl/bsg_snapshot_fifo.sv
// Generic els_p-deep FIFO with push/full and valid/yumi drain; payload is opaque.
module bsg_snapshot_fifo
    import bsg_counter_snapshot_pkg::*;
#(
    parameter int width_p = 64,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               full_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_w_lp = ptr_width(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_r [els_p];
    logic [ptr_w_lp-1:0] wptr_r;
    logic [ptr_w_lp-1:0] rptr_r;
    logic [cnt_w_lp-1:0] count_r;

    function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o = (count_r == cnt_w_lp'(els_p));
    assign v_o    = (count_r != '0);
    assign data_o = mem_r[rptr_r];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
        end else begin
            if (v_i)
                wptr_r <= next_ptr(wptr_r);
            if (yumi_i)
                rptr_r <= next_ptr(rptr_r);
            case ({v_i, yumi_i})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // NOTE: storage is not reset; v_o qualifies data_o, so stale contents are never observed.
    always_ff @(posedge clk_i) begin
        if (v_i)
            mem_r[wptr_r] <= data_i;
    end

endmodule

// File: rtl/bsg_counter_snapshot_interval.sv
// Periodic / on-demand snapshot of an upstream event counter with clear handshake.
// Define BSG_COUNTER_SNAPSHOT_TIMESTAMP_EN to store a cycle timestamp with each snapshot (ts_o).
module bsg_counter_snapshot_interval
    import bsg_counter_snapshot_pkg::*;
#(
    parameter int width_p          = width_default_lp,
    parameter int interval_width_p = interval_width_default_lp,
    parameter int els_p            = els_default_lp
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        en_i,
    input  logic                        cfg_v_i,
    input  logic [interval_width_p-1:0] cfg_interval_i,
    input  logic                        sample_i,
    input  logic [width_p-1:0]          count_i,
    output logic                        clear_o,
    output logic                        v_o,
    output logic [width_p-1:0]          data_o,
    input  logic                        yumi_i,
    output logic                        overflow_o
`ifdef BSG_COUNTER_SNAPSHOT_TIMESTAMP_EN
   ,output logic [width_p-1:0]          ts_o
`endif
);

    typedef struct packed {
`ifdef BSG_COUNTER_SNAPSHOT_TIMESTAMP_EN
        logic [width_p-1:0] ts;
`endif
        logic [width_p-1:0] count;
    } entry_s;

    state_e                      state_r;
    logic [interval_width_p-1:0] interval_r;
    logic [interval_width_p-1:0] timer_r;
    logic                        overflow_r;

    logic   fire;
    logic   capture_req;
    logic   push;
    logic   drop;
    logic   fifo_full;
    entry_s push_entry;
    entry_s head_entry;

    // Firing on timer==1 makes the clear-to-clear period exactly interval_r cycles.
    assign fire        = ((interval_r != '0) && (timer_r == interval_width_p'(1))) || sample_i;
    assign capture_req = (state_r == RUN) && en_i && fire;
    assign push        = capture_req && (!fifo_full || yumi_i);
    assign drop        = capture_req && fifo_full && !yumi_i;

    // A dropped sample leaves the counter running so the next snapshot spans both intervals.
    assign clear_o    = (state_r == START) || push;
    assign overflow_o = overflow_r;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r    <= IDLE;
            interval_r <= '0;
            timer_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (cfg_v_i)
                interval_r <= cfg_interval_i;

            if (cfg_v_i)
                overflow_r <= 1'b0;
            else if (drop)
                overflow_r <= 1'b1;

            case (state_r)
                IDLE: begin
                    if (en_i)
                        state_r <= START;
                end
                START: begin
                    timer_r <= interval_r;
                    state_r <= en_i ? RUN : IDLE;
                end
                RUN: begin
                    if (!en_i)
                        state_r <= IDLE;
                    if (cfg_v_i)
                        timer_r <= cfg_interval_i;
                    else if (fire)
                        timer_r <= interval_r;
                    else if (timer_r != '0)
                        timer_r <= timer_r - 1'b1;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

`ifdef BSG_COUNTER_SNAPSHOT_TIMESTAMP_EN
    logic [width_p-1:0] ts_r;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            ts_r <= '0;
        else
            ts_r <= ts_r + 1'b1;
    end

    assign push_entry.ts = ts_r;
    assign ts_o          = head_entry.ts;
`endif

    assign push_entry.count = count_i;
    assign data_o           = head_entry.count;

    bsg_snapshot_fifo #(
        .width_p ($bits(entry_s)),
        .els_p   (els_p)
    ) fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (push_entry),
        .v_i     (push),
        .full_o  (fifo_full),
        .v_o     (v_o),
        .data_o  (head_entry),
        .yumi_i  (yumi_i)
    );

endmodule

// File: tb/tb_bsg_counter_snapshot_interval.sv
// Self-checking bench: upstream clear/up counter model plus a snapshot scoreboard.
// Exercises the timestamp path when BSG_COUNTER_SNAPSHOT_TIMESTAMP_EN is defined.
module tb_bsg_counter_snapshot_interval;

    localparam int W   = 64;
    localparam int IW  = 32;
    localparam int ELS = 2;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          en_i;
    logic          cfg_v_i;
    logic [IW-1:0] cfg_interval_i;
    logic          sample_i;
    logic [W-1:0]  count_i;
    logic          clear_o;
    logic          v_o;
    logic [W-1:0]  data_o;
    logic          yumi_i;
    logic          overflow_o;
`ifdef BSG_COUNTER_SNAPSHOT_TIMESTAMP_EN
    logic [W-1:0]  ts_o;
    logic [W-1:0]  ts_q [$];
`endif

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] exp_q [$];
    logic         auto_drain;
    logic         last_clear;
    logic         up;

    always #5 clk = ~clk;

    bsg_counter_snapshot_interval #(
        .width_p          (W),
        .interval_width_p (IW),
        .els_p            (ELS)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .en_i           (en_i),
        .cfg_v_i        (cfg_v_i),
        .cfg_interval_i (cfg_interval_i),
        .sample_i       (sample_i),
        .count_i        (count_i),
        .clear_o        (clear_o),
        .v_o            (v_o),
        .data_o         (data_o),
        .yumi_i         (yumi_i),
        .overflow_o     (overflow_o)
`ifdef BSG_COUNTER_SNAPSHOT_TIMESTAMP_EN
       ,.ts_o           (ts_o)
`endif
    );

    // Upstream clear/up counter: on clear its next value is the current up.
    always @(posedge clk) begin
        count_i <= clear_o ? W'(up) : count_i + W'(up);
    end

    // One cycle: starts at a negedge with inputs already driven, ends at the next negedge.
    task automatic tick();
        logic [W-1:0] e;
        yumi_i = auto_drain && v_o;
        if (yumi_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got data_o=%0d, required no snapshot", data_o);
            end else begin
                e = exp_q.pop_front();
                if (data_o !== e) begin
                    errors++;
                    $display("FAIL snapshot_data: got %0d, required %0d", data_o, e);
                end
            end
`ifdef BSG_COUNTER_SNAPSHOT_TIMESTAMP_EN
            ts_q.push_back(ts_o);
`endif
        end
        #1;
        last_clear = clear_o;
        @(posedge clk);
        @(negedge clk);
        yumi_i = 1'b0;
    endtask

    task automatic do_reset();
        reset_i        = 1'b1;
        en_i           = 1'b0;
        cfg_v_i        = 1'b0;
        cfg_interval_i = '0;
        sample_i       = 1'b0;
        auto_drain     = 1'b0;
        yumi_i         = 1'b0;
        tick();
        reset_i = 1'b0;
        exp_q.delete();
    endtask

    task automatic configure(input logic [IW-1:0] interval);
        cfg_v_i        = 1'b1;
        cfg_interval_i = interval;
        tick();
        cfg_v_i = 1'b0;
    endtask

    task automatic enable_through_start();
        en_i = 1'b1;
        tick();
        checks++;
        if (last_clear !== 1'b0) begin
            errors++;
            $display("FAIL idle_clear: got %b, required 0", last_clear);
        end
        tick();
        checks++;
        if (last_clear !== 1'b1) begin
            errors++;
            $display("FAIL start_clear: got %b, required 1", last_clear);
        end
    endtask

    task automatic test_reset();
        reset_i    = 1'b1;
        en_i       = 1'b0;
        cfg_v_i    = 1'b0;
        sample_i   = 1'b0;
        auto_drain = 1'b0;
        yumi_i     = 1'b0;
        cfg_interval_i = '0;
        #1;
        checks++;
        if ({v_o, clear_o, overflow_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outputs: got v/clear/ovf=%b, required 000", {v_o, clear_o, overflow_o});
        end
        tick();
        reset_i = 1'b0;
        en_i    = 1'b0;
        tick();
        checks++;
        if (last_clear !== 1'b0 || v_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got clear=%b v=%b, required 0 0", last_clear, v_o);
        end
    endtask

    task automatic test_periodic();
        do_reset();
        configure(4);
        enable_through_start();
        auto_drain = 1'b1;
        repeat (3) exp_q.push_back(4);
        for (int i = 1; i <= 12; i++) begin
            tick();
            checks++;
            if (last_clear !== (i % 4 == 0)) begin
                errors++;
                $display("FAIL periodic_clear_%0d: got %b, required %b", i, last_clear, (i % 4 == 0));
            end
        end
        en_i = 1'b0;
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL periodic_drained: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_manual_sample();
        do_reset();
        configure(0);
        enable_through_start();
        auto_drain = 1'b1;
        exp_q.push_back(7);
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++;
            if (last_clear !== 1'b0) begin
                errors++;
                $display("FAIL manual_no_timer_%0d: got %b, required 0", i, last_clear);
            end
        end
        sample_i = 1'b1;
        tick();
        sample_i = 1'b0;
        checks++;
        if (last_clear !== 1'b1) begin
            errors++;
            $display("FAIL manual_clear: got %b, required 1", last_clear);
        end
        tick();
        checks++;
        if (last_clear !== 1'b0) begin
            errors++;
            $display("FAIL manual_clear_once: got %b, required 0", last_clear);
        end
        tick();
        checks++;
        if (overflow_o !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL manual_done: got ovf=%b pending=%0d, required 0 0", overflow_o, exp_q.size());
        end
        en_i = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        do_reset();
        configure(3);
        enable_through_start();
        exp_q.push_back(3);
        exp_q.push_back(3);
        exp_q.push_back(6);
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++;
            if (last_clear !== (i == 3 || i == 6)) begin
                errors++;
                $display("FAIL overflow_clear_%0d: got %b, required %b", i, last_clear, (i == 3 || i == 6));
            end
        end
        checks++;
        if (overflow_o !== 1'b1 || v_o !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: got ovf=%b v=%b, required 1 1", overflow_o, v_o);
        end
        auto_drain = 1'b1;
        for (int i = 10; i <= 12; i++) begin
            tick();
            checks++;
            if (last_clear !== (i == 12)) begin
                errors++;
                $display("FAIL merged_clear_%0d: got %b, required %b", i, last_clear, (i == 12));
            end
        end
        tick();
        checks++;
        if (overflow_o !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL overflow_sticky: got ovf=%b pending=%0d, required 1 0", overflow_o, exp_q.size());
        end
        configure(3);
        checks++;
        if (overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL overflow_cfg_clear: got %b, required 0", overflow_o);
        end
        en_i = 1'b0;
        tick();
    endtask

    task automatic test_full_with_yumi();
        do_reset();
        configure(2);
        enable_through_start();
        repeat (3) exp_q.push_back(2);
        for (int i = 1; i <= 5; i++) tick();
        checks++;
        if (v_o !== 1'b1) begin
            errors++;
            $display("FAIL full_valid: got %b, required 1", v_o);
        end
        auto_drain = 1'b1;
        tick();
        checks++;
        if (last_clear !== 1'b1) begin
            errors++;
            $display("FAIL full_yumi_clear: got %b, required 1", last_clear);
        end
        checks++;
        if (overflow_o !== 1'b0 || v_o !== 1'b1) begin
            errors++;
            $display("FAIL full_yumi_state: got ovf=%b v=%b, required 0 1", overflow_o, v_o);
        end
        en_i = 1'b0;
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0 || v_o !== 1'b0) begin
            errors++;
            $display("FAIL full_yumi_drain: got pending=%0d v=%b, required 0 0", exp_q.size(), v_o);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        configure(4);
        enable_through_start();
        for (int i = 1; i <= 5; i++) tick();
        checks++;
        if (v_o !== 1'b1) begin
            errors++;
            $display("FAIL areset_buffered: got %b, required 1", v_o);
        end
        sample_i = 1'b1;
        #1;
        checks++;
        if (clear_o !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre_clear: got %b, required 1", clear_o);
        end
        reset_i = 1'b1;
        #1;
        checks++;
        if ({v_o, clear_o, overflow_o} !== 3'b000) begin
            errors++;
            $display("FAIL areset_immediate: got v/clear/ovf=%b, required 000", {v_o, clear_o, overflow_o});
        end
        sample_i = 1'b0;
        @(negedge clk);
        reset_i = 1'b0;
        exp_q.delete();
        enable_through_start();
        tick();
        checks++;
        if (last_clear !== 1'b0) begin
            errors++;
            $display("FAIL areset_run_clear: got %b, required 0", last_clear);
        end
        en_i = 1'b0;
        tick();
    endtask

`ifdef BSG_COUNTER_SNAPSHOT_TIMESTAMP_EN
    task automatic test_timestamp();
        do_reset();
        configure(5);
        enable_through_start();
        auto_drain = 1'b1;
        ts_q.delete();
        repeat (3) exp_q.push_back(5);
        for (int i = 1; i <= 16; i++) tick();
        checks++;
        if (ts_q.size() != 3) begin
            errors++;
            $display("FAIL ts_count: got %0d, required 3", ts_q.size());
        end else begin
            for (int k = 1; k < 3; k++) begin
                checks++;
                if (ts_q[k] - ts_q[k-1] !== W'(5)) begin
                    errors++;
                    $display("FAIL ts_delta_%0d: got %0d, required 5", k, ts_q[k] - ts_q[k-1]);
                end
            end
        end
        en_i = 1'b0;
        tick();
    endtask
`endif

    initial begin
        up      = 1'b1;
        count_i = '0;
        @(negedge clk);
        test_reset();
        test_periodic();
        test_manual_sample();
        test_overflow();
        test_full_with_yumi();
        test_async_reset();
`ifdef BSG_COUNTER_SNAPSHOT_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
